// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        BCK_PRCH = 2'd2
    } spi_mstr_state_t;

    localparam int unsigned          SCLK_DIV_W  = 5;
    localparam logic [SCLK_DIV_W-1:0] SCLK_PRESET = 5'b10111;
    localparam int unsigned          SPI_BITS    = 16;

endpackage

// File: rtl/spi_mstr.sv
// 16-bit SPI master: SCLK idles high, data shifts out MSB first and MISO is
// captured on every SCLK fall; SS_n is held for a back porch after the last bit.
module spi_mstr
    import spi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        done,
    output logic [15:0] rd_data
);

    spi_mstr_state_t         state, state_nxt;
    logic [SCLK_DIV_W-1:0]   sclk_div;
    logic [4:0]              bit_cnt;
    logic [SPI_BITS-1:0]     shft_reg;
    logic                    load, shift, finish, fall;

    // The divider wrapping 31->0 is the edge on which SCLK falls.
    assign fall = (sclk_div == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (wrt) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (fall) begin
                    shift = 1'b1;
                    if (bit_cnt == 5'(SPI_BITS - 1)) begin
                        state_nxt = BCK_PRCH;
                    end
                end
            end
            BCK_PRCH: begin
                if (sclk_div == 5'd15) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_div <= '0;
            bit_cnt  <= '0;
            shft_reg <= '0;
            SS_n     <= 1'b1;
            done     <= 1'b0;
        end else if (load) begin
            shft_reg <= cmd;
            sclk_div <= SCLK_PRESET;
            bit_cnt  <= '0;
            SS_n     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (state != IDLE) begin
                sclk_div <= sclk_div + 5'd1;
            end
            if (shift) begin
                shft_reg <= {shft_reg[SPI_BITS-2:0], MISO};
                bit_cnt  <= bit_cnt + 5'd1;
            end
            if (finish) begin
                SS_n <= 1'b1;
                done <= 1'b1;
            end
        end
    end

    assign SCLK    = (state == IDLE) ? 1'b1 : sclk_div[SCLK_DIV_W-1];
    assign MOSI    = shft_reg[SPI_BITS-1];
    assign rd_data = shft_reg;

endmodule

// File: tb/tb_spi_mstr.sv
// Directed bench for spi_mstr with a behavioural SPI slave that captures MOSI
// and drives MISO on SCLK falls.
module tb_spi_mstr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wrt = 1'b0;
    logic [15:0] cmd = '0;
    logic        MISO;
    logic        SS_n, SCLK, MOSI, done;
    logic [15:0] rd_data;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    spi_mstr dut (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .cmd     (cmd),
        .MISO    (MISO),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .done    (done),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model and bus monitor, evaluated mid-cycle
    logic [15:0] slave_load = '0;
    logic [15:0] slave_tx   = '0;
    logic [15:0] slave_rx   = '0;
    logic        sclk_q = 1'b1, ssn_q = 1'b1, mosi_q = 1'b0, done_q = 1'b0;
    int fall_cnt = 0, first_fall = 0, last_fall = 0, spacing_err = 0;
    int ssn_fall = 0, ssn_rise = 0, extra_edge = 0, done_rises = 0;

    assign MISO = slave_tx[15];

    always @(negedge clk) begin
        if (ssn_q && !SS_n) begin
            ssn_fall    = cyc;
            slave_tx    = slave_load;
            fall_cnt    = 0;
            spacing_err = 0;
            extra_edge  = 0;
        end
        if (!ssn_q && SS_n) ssn_rise = cyc;
        if (sclk_q && !SCLK && !SS_n) begin
            fall_cnt = fall_cnt + 1;
            if (fall_cnt == 1) first_fall = cyc;
            else if (cyc - last_fall != 32) spacing_err = spacing_err + 1;
            if (fall_cnt > 16) extra_edge = extra_edge + 1;
            last_fall = cyc;
            slave_rx  = {slave_rx[14:0], mosi_q};
            slave_tx  = {slave_tx[14:0], 1'b0};
        end
        if (!sclk_q && SCLK && !SS_n && fall_cnt >= 16) extra_edge = extra_edge + 1;
        if (!done_q && done) done_rises = done_rises + 1;
        sclk_q = SCLK;
        ssn_q  = SS_n;
        mosi_q = MOSI;
        done_q = done;
    end

    task automatic start_xfer(input logic [15:0] c, input logic [15:0] sl, output int n);
        @(posedge clk); #1;
        slave_load = sl;
        cmd = c;
        wrt = 1'b1;
        n   = cyc;
        @(posedge clk); #1;
        wrt = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        for (int i = 0; i < 700; i++) begin
            if (done) break;
            @(posedge clk); #1;
        end
        dc = cyc;
        if (!done) begin
            total = total + 1;
            $display("FAIL wait_done: done=%0b required 1 within 700 cycles", done);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total = total + 1;
        if ({SS_n, SCLK, done, MOSI} !== 4'b1100)
            $display("FAIL reset_ctrl: SS_n/SCLK/done/MOSI=%b required 1100", {SS_n, SCLK, done, MOSI});
        else passed = passed + 1;
        total = total + 1;
        if (rd_data !== 16'h0000) $display("FAIL reset_rd_data: got %h required 0000", rd_data);
        else passed = passed + 1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total = total + 1;
        if ({SS_n, SCLK, done} !== 3'b110)
            $display("FAIL idle_after_reset: SS_n/SCLK/done=%b required 110", {SS_n, SCLK, done});
        else passed = passed + 1;
    endtask

    task automatic test_single;
        int n, dc;
        start_xfer(16'h8001, 16'h0000, n);
        total = total + 1;
        if ({SS_n, SCLK, MOSI, done} !== 4'b0110)
            $display("FAIL single_load: SS_n/SCLK/MOSI/done=%b required 0110", {SS_n, SCLK, MOSI, done});
        else passed = passed + 1;
        wait_done(dc);
        @(negedge clk); #1;
        total = total + 1;
        if (dc - n !== 506) $display("FAIL single_latency: got %0d required 506", dc - n);
        else passed = passed + 1;
        total = total + 1;
        if (ssn_fall - n !== 1 || ssn_rise - n !== 506)
            $display("FAIL single_ss_window: low %0d..%0d required 1..506", ssn_fall - n, ssn_rise - n);
        else passed = passed + 1;
        total = total + 1;
        if (fall_cnt !== 16 || first_fall - n !== 10 || last_fall - n !== 490 || spacing_err !== 0)
            $display("FAIL single_sclk: falls=%0d first=%0d last=%0d spacing_err=%0d required 16/10/490/0",
                     fall_cnt, first_fall - n, last_fall - n, spacing_err);
        else passed = passed + 1;
        total = total + 1;
        if (extra_edge !== 0) $display("FAIL single_back_porch: edges=%0d required 0", extra_edge);
        else passed = passed + 1;
        total = total + 1;
        if (slave_rx !== 16'h8001) $display("FAIL single_mosi: got %h required 8001", slave_rx);
        else passed = passed + 1;
    endtask

    task automatic test_loopback;
        int n, dc;
        start_xfer(16'hA5C3, 16'h1234, n);
        wait_done(dc);
        @(negedge clk); #1;
        total = total + 1;
        if (dc - n !== 506) $display("FAIL loop_latency: got %0d required 506", dc - n);
        else passed = passed + 1;
        total = total + 1;
        if (slave_rx !== 16'hA5C3) $display("FAIL loop_slave_rx: got %h required A5C3", slave_rx);
        else passed = passed + 1;
        total = total + 1;
        if (rd_data !== 16'h1234) $display("FAIL loop_rd_data: got %h required 1234", rd_data);
        else passed = passed + 1;
        repeat (40) @(posedge clk);
        #1;
        total = total + 1;
        if (rd_data !== 16'h1234 || done !== 1'b1)
            $display("FAIL loop_hold: rd_data=%h done=%b required 1234 1", rd_data, done);
        else passed = passed + 1;
    endtask

    task automatic test_ignored_wrt;
        int n, dc, r0;
        r0 = done_rises;
        start_xfer(16'h1357, 16'h2468, n);
        for (int k = 0; k < 2; k++) begin
            while (cyc < n + 100 + 200 * k) begin
                @(posedge clk); #1;
            end
            cmd = 16'hFFFF;
            wrt = 1'b1;
            @(posedge clk); #1;
            wrt = 1'b0;
        end
        wait_done(dc);
        repeat (20) @(posedge clk);
        #1;
        total = total + 1;
        if (dc - n !== 506) $display("FAIL ignore_latency: got %0d required 506", dc - n);
        else passed = passed + 1;
        total = total + 1;
        if (slave_rx !== 16'h1357) $display("FAIL ignore_slave_rx: got %h required 1357", slave_rx);
        else passed = passed + 1;
        total = total + 1;
        if (done_rises - r0 !== 1 || rd_data !== 16'h2468)
            $display("FAIL ignore_done_once: rises=%0d rd_data=%h required 1 2468", done_rises - r0, rd_data);
        else passed = passed + 1;
    endtask

    task automatic test_reset_abort;
        int n, dc, r0;
        start_xfer(16'hC3C3, 16'h5555, n);
        while (cyc < n + 200) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        total = total + 1;
        if ({SS_n, SCLK, done, MOSI} !== 4'b1100 || rd_data !== 16'h0000)
            $display("FAIL abort_immediate: SS_n/SCLK/done/MOSI=%b rd_data=%h required 1100 0000",
                     {SS_n, SCLK, done, MOSI}, rd_data);
        else passed = passed + 1;
        @(posedge clk); #1;
        rst = 1'b0;
        r0 = done_rises;
        repeat (30) @(posedge clk);
        #1;
        total = total + 1;
        if (SS_n !== 1'b1 || done !== 1'b0 || done_rises !== r0)
            $display("FAIL abort_quiet: SS_n=%b done=%b rises=%0d required 1 0 0", SS_n, done, done_rises - r0);
        else passed = passed + 1;
        start_xfer(16'h0F0F, 16'h9A5C, n);
        wait_done(dc);
        @(negedge clk); #1;
        total = total + 1;
        if (dc - n !== 506 || slave_rx !== 16'h0F0F || rd_data !== 16'h9A5C)
            $display("FAIL abort_recover: latency=%0d slave_rx=%h rd_data=%h required 506 0F0F 9A5C",
                     dc - n, slave_rx, rd_data);
        else passed = passed + 1;
    endtask

    task automatic test_back_to_back;
        int n, dc, dc2;
        start_xfer(16'h0001, 16'hBEEF, n);
        // wrt sampled on the very edge that raises done must be dropped
        while (cyc < n + 505) begin
            @(posedge clk); #1;
        end
        cmd = 16'h1111;
        wrt = 1'b1;
        @(posedge clk); #1;
        wrt = 1'b0;
        wait_done(dc);
        total = total + 1;
        if (dc - n !== 506 || SS_n !== 1'b1 || rd_data !== 16'hBEEF)
            $display("FAIL b2b_first: latency=%0d SS_n=%b rd_data=%h required 506 1 BEEF", dc - n, SS_n, rd_data);
        else passed = passed + 1;
        cmd = 16'hFFFE;
        wrt = 1'b1;
        @(posedge clk); #1;
        wrt = 1'b0;
        total = total + 1;
        if ({done, SS_n, MOSI} !== 3'b001)
            $display("FAIL b2b_accept: done/SS_n/MOSI=%b required 001", {done, SS_n, MOSI});
        else passed = passed + 1;
        total = total + 1;
        if (slave_rx !== 16'h0001) $display("FAIL b2b_first_rx: got %h required 0001", slave_rx);
        else passed = passed + 1;
        slave_load = 16'h7E81;
        wait_done(dc2);
        @(negedge clk); #1;
        total = total + 1;
        if (dc2 - dc !== 506 || slave_rx !== 16'hFFFE)
            $display("FAIL b2b_second: latency=%0d slave_rx=%h required 506 FFFE", dc2 - dc, slave_rx);
        else passed = passed + 1;
    endtask

    initial begin
        test_reset;
        test_single;
        test_loopback;
        test_ignored_wrt;
        test_reset_abort;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
